// File: rtl/tdm_demux8_if.sv
// Signal bundle between a TDM sample source and the 8-slot demultiplexer.
// master drives samples; slave returns the reassembled frame and status.
interface tdm_demux8_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [8*W-1:0] dout;
  logic           dout_valid;
  logic [2:0]     s;
  logic           sync_err;
  logic           locked;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, s, sync_err, locked
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, s, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux8.sv
// Receive end of an 8-slot TDM link: hunts for frame_sync, collects slots 0..7
// into a shadow register and publishes whole frames to dout atomically.
module tdm_demux8 #(
  parameter int unsigned W = 1
) (
  input logic         clk,
  input logic         rst,
  tdm_demux8_if.slave bus
);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e               state_q, state_d;
  logic [2:0]           s_q, s_d;
  logic [6:0][W-1:0]    shadow_q, shadow_d;
  logic [8*W-1:0]       dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 sync_err_q, sync_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHunt;
      s_q          <= 3'd0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (bus.frame_sync) begin
            shadow_d[0] = bus.din;
            s_d         = 3'd1;
            state_d     = StLock;
          end
        end
        StLock: begin
          if (bus.frame_sync) begin
            // Early sync restarts the frame; stale shadow slots get overwritten
            // before they can ever reach dout.
            sync_err_d  = (s_q != 3'd0);
            shadow_d[0] = bus.din;
            s_d         = 3'd1;
          end else if (s_q == 3'd0) begin
            sync_err_d = 1'b1;
            state_d    = StHunt;
            s_d        = 3'd0;
          end else if (s_q == 3'd7) begin
            dout_d       = {bus.din, shadow_q};
            dout_valid_d = 1'b1;
            s_d          = 3'd0;
          end else begin
            for (int k = 1; k < 7; k++) begin
              if (s_q == 3'(k)) shadow_d[k] = bus.din;
            end
            s_d = s_q + 3'd1;
          end
        end
        default: begin
          state_d = StHunt;
          s_d     = 3'd0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.s          = s_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == StLock);

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8 (W=1): directed frames push expected pulses,
// a negedge monitor pops and compares whenever dout_valid or sync_err fires.
module tb_tdm_demux8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demux8_if #(.W(1)) bus ();

  tdm_demux8 #(.W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1 || bus.sync_err === 1'b1) begin
      exp_t e;
      check("pulse_exclusive", {7'd0, bus.dout_valid & bus.sync_err}, 8'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_pulse: got dout_valid=%0b sync_err=%0b expected none",
                 bus.dout_valid, bus.sync_err);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {7'd0, bus.sync_err}, {7'd0, e.is_err});
        check("pulse_dout", bus.dout, e.dout);
      end
    end
  end

  task automatic drive(input logic b, input logic fs);
    @(negedge clk);
    bus.din        = b;
    bus.din_valid  = 1'b1;
    bus.frame_sync = fs;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = 1'b0;
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.dout   = d;
    exp_q.push_back(e);
  endtask

  task automatic check_state(input string name, input logic [2:0] s_w, input logic lk_w,
                             input logic [7:0] d_w);
    check({name, "_s"}, {5'd0, bus.s}, {5'd0, s_w});
    check({name, "_locked"}, {7'd0, bus.locked}, {7'd0, lk_w});
    check({name, "_dout"}, bus.dout, d_w);
  endtask

  initial begin
    logic [7:0] frame_a;
    frame_a = 8'b0100_1101;  // slots 0..7 = 1,0,1,1,0,0,1,0

    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    check_state("reset", 3'd0, 1'b0, 8'h00);
    check("reset_dv", {7'd0, bus.dout_valid}, 8'd0);
    check("reset_se", {7'd0, bus.sync_err}, 8'd0);
    rst = 1'b0;

    // Back-to-back frame
    for (int k = 0; k < 8; k++) begin
      if (k == 7) push(1'b0, 8'h4D);
      drive(frame_a[k], k == 0);
    end
    idle();
    check_state("frame", 3'd0, 1'b1, 8'h4D);
    idle();

    // Same frame with a gap after each sample; s must hold across gaps
    for (int k = 0; k < 8; k++) begin
      if (k == 7) push(1'b0, 8'h4D);
      drive(frame_a[k], k == 0);
      idle();
      check("gap_s", {5'd0, bus.s}, 8'((k + 1) % 8));
      idle();
      check("gap_s_hold", {5'd0, bus.s}, 8'((k + 1) % 8));
    end
    check("gap_dout", bus.dout, 8'h4D);

    // Missing sync at s=0
    push(1'b1, 8'h4D);
    drive(1'b1, 1'b0);
    idle();
    check_state("missing_sync", 3'd0, 1'b0, 8'h4D);

    // Hunt through 5 unsynced samples, then an all-ones frame
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
    idle();
    check_state("hunt_discard", 3'd0, 1'b0, 8'h4D);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) push(1'b0, 8'hFF);
      drive(1'b1, k == 0);
    end
    idle();
    check_state("all_ones", 3'd0, 1'b1, 8'hFF);

    // Early sync at s=4, then 7 more samples complete the restarted frame
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    idle();
    check("pre_early_s", {5'd0, bus.s}, 8'd4);
    push(1'b1, 8'hFF);
    drive(1'b0, 1'b1);
    idle();
    check_state("early_sync", 3'd1, 1'b1, 8'hFF);
    begin
      logic [6:0] rest;
      rest = 7'b100_0011;  // slots 1..7 = 1,1,0,0,0,0,1
      for (int k = 0; k < 7; k++) begin
        if (k == 6) push(1'b0, 8'h86);
        drive(rest[k], 1'b0);
      end
    end
    idle();
    check_state("after_early", 3'd0, 1'b1, 8'h86);

    // Reset at s=5 with a competing synced sample
    drive(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) drive(k[0], 1'b0);
    idle();
    check("pre_rst_s", {5'd0, bus.s}, 8'd5);
    @(negedge clk);
    rst            = 1'b1;
    bus.din        = 1'b1;
    bus.din_valid  = 1'b1;
    bus.frame_sync = 1'b1;
    @(negedge clk);
    check_state("mid_rst", 3'd0, 1'b0, 8'h00);
    check("mid_rst_dv", {7'd0, bus.dout_valid}, 8'd0);
    check("mid_rst_se", {7'd0, bus.sync_err}, 8'd0);
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (2) @(negedge clk);

    check("pending_events", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
